cam_frame_writer: RTL and testbench
===================================

# cam_frame_writer

Capture stage directly upstream of the 101×101×24-bit frame-buffer RAM. Consumes the camera's byte-serial RGB565 stream (vsync/href framing, one byte per `byte_valid` strobe), assembles pixels, expands them to RGB888, and generates the x/y address and write strobe that load the frame buffer. Also produces per-frame status pulses for the downstream readout logic.

## Interface
Parameters:
- `WIDTH`, 101, stored columns; x range 0..WIDTH-1
- `HEIGHT`, 101, stored rows; y range 0..HEIGHT-1
- `AW`, 7, address width of `x_addr`/`y_addr`; must satisfy 2^AW ≥ max(WIDTH, HEIGHT)

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `vsync`  in  1  camera frame sync; high between frames
- `href`  in  1  camera line valid; high while a line's bytes arrive
- `byte_valid`  in  1  `pix_byte` valid this cycle; at most one byte per cycle
- `pix_byte`  in  8  camera data byte
- `x_addr`  out  AW  frame-buffer column
- `y_addr`  out  AW  frame-buffer row
- `din`  out  24  RGB888 pixel, {R[23:16], G[15:8], B[7:0]}
- `write`  out  1  frame-buffer write strobe, one cycle per stored pixel
- `frame_done`  out  1  one-cycle pulse at the end of each captured frame
- `clipped`  out  1  one-cycle pulse when a pixel is dropped for exceeding WIDTH/HEIGHT

## Operation
- States: SYNC (wait for `vsync`=1), VBLANK (wait for `vsync`=0), ACTIVE (capture).
  - SYNC→VBLANK on `vsync`=1.
  - VBLANK→ACTIVE on `vsync`=0; source column `sx`, source row `sy`, and byte phase clear.
  - ACTIVE→VBLANK on `vsync`=1; `frame_done` pulses on the following cycle, only if at least one pixel was written this frame.
- Capture only in ACTIVE with `href`=1 and `byte_valid`=1.
  - Phase 0 byte latched as `hi` = {R5, G6[5:3]}.
  - Phase 1 byte `lo` = {G6[2:0], B5} completes the pixel.
  - Phase toggles on each accepted byte.
- RGB565→RGB888 expansion by bit replication:
  - R8 = {R5, R5[4:2]}
  - G8 = {G6, G6[5:4]}
  - B8 = {B5, B5[4:2]}
- On each completed pixel:
  - If the pixel is kept (see Configuration) and dx < WIDTH and dy < HEIGHT: register `write`=1, `din`, `x_addr`=dx, `y_addr`=dy.
  - If kept but dx ≥ WIDTH or dy ≥ HEIGHT: `write` stays 0 and `clipped` pulses.
  - `sx` increments in all cases, saturating at 2^(AW+1)-1.
- End of line, on `href` falling edge (registered `href` is 1, current `href` is 0) in ACTIVE: `sx` clears, `sy` increments (saturating), phase forces to 0. An odd trailing byte is discarded.
- `href`=1 outside ACTIVE is ignored.

## Timing
- Reset values: state SYNC; `sx`, `sy`, phase, `hi` = 0; `write`, `frame_done`, `clipped` = 0; `x_addr`, `y_addr` = 0; `din` = 0.
- Latency: `write`/`din`/address are valid exactly 1 cycle after the phase-1 `byte_valid` cycle.
- Outputs hold their last value when `write`=0.
- `byte_valid` gaps of any length within a line are tolerated; phase is held across gaps.
- `href` falling on the same cycle as a phase-1 byte: that byte is not accepted, phase resets, and the end-of-line action occurs.
- `vsync` rising while `href`=1: the frame ends, the partial line is abandoned, and no write occurs for the pending phase.
- `reset` mid-frame: all state clears on that edge; capture resumes only after a full SYNC→VBLANK→ACTIVE sequence, so a partial frame is never written.
- Maximum write rate is one write every 2 cycles.

## Configuration
- `CAM_DECIMATE_EN` defined:
  - A pixel is kept only when sx[0]=0 and sy[0]=0.
  - dx = sx>>1, dy = sy>>1, giving a 2:1 reduction in each axis (e.g. 202×202 source → 101×101 stored).
- Not defined: every pixel is kept; dx = sx, dy = sy.

## Test plan
- Reset, then vsync 1→0, then one line of 4 bytes 0xF8,0x00,0x07,0xE0 with href high → writes at (0,0) din=0xFF0000 and (1,0) din=0x00FF00, each 1 cycle after its second byte.
- Byte 0x00,0x1F with a 3-cycle `byte_valid` gap between bytes → single write, din=0x0000FF, phase preserved across the gap.
- 3 lines of 2 pixels each, then vsync rises → y_addr 0,1,2 (0,0,1 with `CAM_DECIMATE_EN`); `frame_done` pulses once.
- Line of WIDTH+2 pixels (no decimation) → WIDTH writes with x 0..100, then two `clipped` pulses and no write.
- Odd byte count (3 bytes) then href falls → one write; next line's first pixel is written at x=0 with correct colour.
- `reset` asserted mid-line → `write` is 0 on the next cycle; pixels from the remainder of that frame are never written.

Source files
------------

// File: rtl/cam_frame_writer.sv
// cam_frame_writer
//   Capture stage in front of the WIDTH x HEIGHT x 24-bit frame buffer.
//   Assembles byte-serial RGB565 camera pixels (vsync/href framing),
//   expands them to RGB888 and produces the frame-buffer address/write
//   strobe plus per-frame status pulses.
//
//   Optional feature macro: CAM_DECIMATE_EN
//     defined   : keep only even source columns/rows, stored at (sx>>1, sy>>1)
//     undefined : every source pixel is kept at (sx, sy)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   vsync      in   camera frame sync, high between frames
//   href       in   camera line valid
//   byte_valid in   pix_byte valid this cycle
//   pix_byte   in   camera data byte [7:0]
//   x_addr     out  frame-buffer column [AW-1:0]
//   y_addr     out  frame-buffer row [AW-1:0]
//   din        out  RGB888 pixel {R,G,B} [23:0]
//   write      out  frame-buffer write strobe
//   frame_done out  one-cycle pulse after a frame with at least one write
//   clipped    out  one-cycle pulse when a kept pixel falls outside the buffer
module cam_frame_writer #(
    parameter int WIDTH  = 101,
    parameter int HEIGHT = 101,
    parameter int AW     = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vsync,
    input  logic          href,
    input  logic          byte_valid,
    input  logic [7:0]    pix_byte,
    output logic [AW-1:0] x_addr,
    output logic [AW-1:0] y_addr,
    output logic [23:0]   din,
    output logic          write,
    output logic          frame_done,
    output logic          clipped
);

    typedef enum logic [1:0] {SYNC, VBLANK, ACTIVE} state_t;

    localparam logic [AW:0] X_LIM = (AW+1)'(WIDTH);
    localparam logic [AW:0] Y_LIM = (AW+1)'(HEIGHT);

    state_t      state, state_next;
    logic [AW:0] sx, sy;
    logic [AW:0] dx, dy;
    logic        phase;
    logic [7:0]  hi;
    logic        href_q;
    logic        wrote;
    logic        enter_active, leave_active;
    logic        capture_ok, accept, line_end, keep;
    logic [4:0]  r5, b5;
    logic [5:0]  g6;

    always_ff @(posedge clk) begin
        if (reset) state <= SYNC;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        enter_active = 1'b0;
        leave_active = 1'b0;
        case (state)
            SYNC:    if (vsync) state_next = VBLANK;
            VBLANK:  if (!vsync) begin
                         state_next   = ACTIVE;
                         enter_active = 1'b1;
                     end
            ACTIVE:  if (vsync) begin
                         state_next   = VBLANK;
                         leave_active = 1'b1;
                     end
            default: state_next = SYNC;
        endcase
    end

    // A byte arriving on the cycle vsync rises belongs to an abandoned line,
    // so capture is gated by vsync as well as by the ACTIVE state.
    always_comb begin
        capture_ok = (state == ACTIVE) && !vsync;
        accept     = capture_ok && href && byte_valid;
        line_end   = capture_ok && href_q && !href;
        r5 = hi[7:3];
        g6 = {hi[2:0], pix_byte[7:5]};
        b5 = pix_byte[4:0];
`ifdef CAM_DECIMATE_EN
        keep = !sx[0] && !sy[0];
        dx   = sx >> 1;
        dy   = sy >> 1;
`else
        keep = 1'b1;
        dx   = sx;
        dy   = sy;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sx         <= '0;
            sy         <= '0;
            phase      <= 1'b0;
            hi         <= '0;
            href_q     <= 1'b0;
            wrote      <= 1'b0;
            write      <= 1'b0;
            frame_done <= 1'b0;
            clipped    <= 1'b0;
            x_addr     <= '0;
            y_addr     <= '0;
            din        <= '0;
        end else begin
            write      <= 1'b0;
            clipped    <= 1'b0;
            frame_done <= leave_active && wrote;
            href_q     <= href;
            if (enter_active) begin
                sx    <= '0;
                sy    <= '0;
                phase <= 1'b0;
                wrote <= 1'b0;
            end else if (line_end) begin
                // A pending phase-0 byte (odd byte count) is simply dropped.
                sx    <= '0;
                phase <= 1'b0;
                if (sy != '1) sy <= sy + 1'b1;
            end else if (accept) begin
                if (!phase) begin
                    hi    <= pix_byte;
                    phase <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    if (sx != '1) sx <= sx + 1'b1;
                    if (keep) begin
                        if (dx < X_LIM && dy < Y_LIM) begin
                            write  <= 1'b1;
                            wrote  <= 1'b1;
                            x_addr <= dx[AW-1:0];
                            y_addr <= dy[AW-1:0];
                            din    <= {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
                        end else begin
                            clipped <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_frame_writer.sv
// Self-checking bench for cam_frame_writer (default build, decimation off).
module tb_cam_frame_writer;

    localparam int W  = 101;
    localparam int H  = 101;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic          vsync;
    logic          href;
    logic          byte_valid;
    logic [7:0]    pix_byte;
    logic [AW-1:0] x_addr;
    logic [AW-1:0] y_addr;
    logic [23:0]   din;
    logic          write;
    logic          frame_done;
    logic          clipped;

    int total = 0;
    int bad   = 0;

    cam_frame_writer #(.WIDTH(W), .HEIGHT(H), .AW(AW)) dut (
        .clk(clk), .reset(reset), .vsync(vsync), .href(href),
        .byte_valid(byte_valid), .pix_byte(pix_byte),
        .x_addr(x_addr), .y_addr(y_addr), .din(din), .write(write),
        .frame_done(frame_done), .clipped(clipped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [23:0] din;
    } vec_t;

    vec_t vt [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        href       = 1'b1;
        byte_valid = 1'b1;
        pix_byte   = b;
        tick();
        byte_valid = 1'b0;
    endtask

    // Send one pixel and check the write that follows its second byte.
    task automatic pix_chk(input string name, input logic [7:0] h, input logic [7:0] l,
                           input int x, input int y, input logic [23:0] d);
        send_byte(h);
        chk({name, "_hi_nowr"}, 32'(write), 32'd0);
        send_byte(l);
        chk({name, "_wr"}, 32'(write), 32'd1);
        chk({name, "_x"},  32'(x_addr), 32'(x));
        chk({name, "_y"},  32'(y_addr), 32'(y));
        chk({name, "_din"}, 32'(din), 32'(d));
    endtask

    task automatic end_line();
        href       = 1'b0;
        byte_valid = 1'b0;
        tick();
        tick();
    endtask

    int fd_cnt;
    int wr_cnt;

    initial begin
        vt[0] = '{hi: 8'hF8, lo: 8'h00, din: 24'hFF0000};
        vt[1] = '{hi: 8'h07, lo: 8'hE0, din: 24'h00FF00};
        vt[2] = '{hi: 8'h00, lo: 8'h1F, din: 24'h0000FF};
        vt[3] = '{hi: 8'hFF, lo: 8'hFF, din: 24'hFFFFFF};
        vt[4] = '{hi: 8'h84, lo: 8'h10, din: 24'h848284};
        vt[5] = '{hi: 8'h08, lo: 8'h21, din: 24'h080408};
        vt[6] = '{hi: 8'h52, lo: 8'hAA, din: 24'h525552};

        reset = 1'b1; vsync = 1'b0; href = 1'b0; byte_valid = 1'b0; pix_byte = '0;
        tick(); tick();
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_fdone", 32'(frame_done), 32'd0);
        chk("rst_clip",  32'(clipped), 32'd0);
        chk("rst_x",     32'(x_addr), 32'd0);
        chk("rst_y",     32'(y_addr), 32'd0);
        chk("rst_din",   32'(din), 32'd0);
        reset = 1'b0;
        tick();

        // Bytes before any vsync are ignored (state SYNC).
        send_byte(8'hF8); send_byte(8'h00);
        chk("sync_ignore", 32'(write), 32'd0);
        end_line();

        // Frame 1: table-driven colours on row 0.
        vsync = 1'b1; tick();
        vsync = 1'b0; tick();
        for (int i = 0; i < 7; i++) begin
            pix_chk($sformatf("vec%0d", i), vt[i].hi, vt[i].lo, i, 0, vt[i].din);
        end
        tick();
        chk("hold_wr",  32'(write), 32'd0);
        chk("hold_din", 32'(din), 32'h525552);
        chk("hold_x",   32'(x_addr), 32'd6);

        // Gap of 3 cycles between the two bytes of one pixel.
        send_byte(8'h00);
        for (int g = 0; g < 3; g++) begin
            tick();
            chk("gap_nowr", 32'(write), 32'd0);
        end
        send_byte(8'h1F);
        chk("gap_wr",  32'(write), 32'd1);
        chk("gap_din", 32'(din), 32'h0000FF);
        chk("gap_x",   32'(x_addr), 32'd7);
        end_line();
        vsync = 1'b1; tick();
        chk("f1_done", 32'(frame_done), 32'd1);
        tick();
        chk("f1_done_off", 32'(frame_done), 32'd0);

        // Frame 2: three lines of two pixels, frame_done exactly once.
        vsync = 1'b0; tick();
        for (int l = 0; l < 3; l++) begin
            pix_chk("ml_p0", 8'hF8, 8'h00, 0, l, 24'hFF0000);
            pix_chk("ml_p1", 8'h07, 8'hE0, 1, l, 24'h00FF00);
            end_line();
        end
        vsync = 1'b1;
        fd_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (frame_done) fd_cnt++;
        end
        chk("ml_fdone_cnt", 32'(fd_cnt), 32'd1);

        // Frame 3: WIDTH+2 pixels on one line -> two clipped pulses.
        vsync = 1'b0; tick();
        for (int p = 0; p < W + 2; p++) begin
            send_byte(8'h84);
            send_byte(8'h10);
            if (p < W) begin
                chk("wid_wr",   32'(write), 32'd1);
                chk("wid_x",    32'(x_addr), 32'(p));
                chk("wid_clip", 32'(clipped), 32'd0);
            end else begin
                chk("clip_wr",    32'(write), 32'd0);
                chk("clip_pulse", 32'(clipped), 32'd1);
                chk("clip_xhold", 32'(x_addr), 32'(W - 1));
            end
        end
        tick();
        chk("clip_off", 32'(clipped), 32'd0);
        end_line();

        // Odd byte count: trailing byte dropped, next line starts cleanly.
        pix_chk("odd_p0", 8'h07, 8'hE0, 0, 1, 24'h00FF00);
        send_byte(8'hF8);
        end_line();
        chk("odd_nowr", 32'(write), 32'd0);
        pix_chk("odd_next", 8'h00, 8'h1F, 0, 2, 24'h0000FF);

        // href falls together with a phase-1 byte: byte rejected, line ends.
        send_byte(8'hF8);
        href = 1'b0; byte_valid = 1'b1; pix_byte = 8'h00;
        tick();
        byte_valid = 1'b0;
        chk("hfall_nowr", 32'(write), 32'd0);
        tick();
        pix_chk("hfall_next", 8'h07, 8'hE0, 0, 3, 24'h00FF00);

        // vsync rises with a phase-1 byte pending: no write, frame ends.
        send_byte(8'hF8);
        vsync = 1'b1; href = 1'b1; byte_valid = 1'b1; pix_byte = 8'h00;
        tick();
        byte_valid = 1'b0; href = 1'b0;
        chk("vs_nowr",  32'(write), 32'd0);
        chk("vs_fdone", 32'(frame_done), 32'd1);
        tick();

        // Frame 4: reset mid-line, remainder of frame must not be written.
        vsync = 1'b0; tick();
        pix_chk("pre_rst", 8'hFF, 8'hFF, 0, 0, 24'hFFFFFF);
        send_byte(8'hF8);
        reset = 1'b1; href = 1'b1; byte_valid = 1'b1; pix_byte = 8'h00;
        tick();
        byte_valid = 1'b0;
        chk("mrst_nowr", 32'(write), 32'd0);
        reset = 1'b0;
        wr_cnt = 0;
        for (int p = 0; p < 6; p++) begin
            send_byte(8'h07);
            if (write) wr_cnt++;
            send_byte(8'hE0);
            if (write) wr_cnt++;
        end
        end_line();
        chk("mrst_no_writes", 32'(wr_cnt), 32'd0);
        vsync = 1'b1; tick();
        chk("mrst_no_fdone", 32'(frame_done), 32'd0);
        vsync = 1'b0; tick();
        pix_chk("post_rst", 8'h52, 8'hAA, 0, 0, 24'h525552);
        end_line();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
